regfile_debug_master: RTL and testbench

//   Initiator side of the register-file access interface. Lets a debug/test host read and write the

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/regfile_debug_master.sv | 213 +++++++++++++++++++++
 tb/tb_regfile_debug_master.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the multicycle RISC-V core and its debug side.
//   XLEN / XWIDTH  data width and register-address width
//   NUM_REGS       architectural register count (x0..x31)
//   dbg_state_e    state encoding of the register-file debug master
//   dbg_req_t      request fields latched by the debug master at acceptance
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int XWIDTH   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [2:0] {
        DM_IDLE,
        DM_ACCESS,
        DM_RESP,
        DM_DUMP
    } dbg_state_e;

    typedef struct packed {
        logic              write;
        logic [XWIDTH-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } dbg_req_t;

endpackage

// File: rtl/regfile_debug_master.sv
// regfile_debug_master: initiator side of the register-file debug access channel.
// Lets a host read and write x0..x31 over a valid/ready request/response pair while
// the core is halted. Drives the register-file port that the core top muxes in when halted.
//
// Optional feature: define REGFILE_DUMP_EN to add a bulk dump of all 32 registers
// started by dump_i. Without it dump_i is ignored.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   halted_i                       core halted; requests only succeed while high
//   req_valid_i / req_ready_o      request handshake (ready only in IDLE)
//   req_write_i, req_addr_i,
//   req_wdata_i                    request fields, latched at acceptance
//   dump_i                         start bulk dump (REGFILE_DUMP_EN builds)
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_last_o                     response payload
//   rf_rd_addr_o / rf_rd_data_i    register-file read port (combinational data)
//   rf_wr_addr_o, rf_wr_data_o,
//   rf_wr_en_o                     register-file write port, enable is a 1-cycle pulse
//   busy_o                         FSM not in IDLE
module regfile_debug_master
    import riscv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              halted_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [XWIDTH-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic              dump_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_last_o,
    output logic [XWIDTH-1:0] rf_rd_addr_o,
    input  logic [XLEN-1:0]   rf_rd_data_i,
    output logic [XWIDTH-1:0] rf_wr_addr_o,
    output logic [XLEN-1:0]   rf_wr_data_o,
    output logic              rf_wr_en_o,
    output logic              busy_o
);

    dbg_state_e      state_q, state_d;
    dbg_req_t        req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            last_q, last_d;

`ifdef REGFILE_DUMP_EN
    logic [XWIDTH-1:0] idx_q, idx_d;   // register currently being dumped
    logic              beat_q, beat_d; // current dump beat is on the response channel
`else
    logic unused_dump;
    assign unused_dump = dump_i;
`endif

    // ------------------------------------------------------------------
    // State and response registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DM_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
`ifdef REGFILE_DUMP_EN
            idx_q   <= '0;
            beat_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            last_q  <= last_d;
`ifdef REGFILE_DUMP_EN
            idx_q   <= idx_d;
            beat_q  <= beat_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-response logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a hold default before the case statement so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        last_d  = last_q;
`ifdef REGFILE_DUMP_EN
        idx_d   = idx_q;
        beat_d  = beat_q;
`endif

        case (state_q)
            DM_IDLE: begin
`ifdef REGFILE_DUMP_EN
                // A dump request wins over a pending single access.
                if (dump_i) begin
                    rdata_d = '0;
                    if (halted_i) begin
                        state_d = DM_DUMP;
                        idx_d   = '0;
                        beat_d  = 1'b0;
                        err_d   = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = DM_RESP;
                        err_d   = 1'b1;
                        last_d  = 1'b1;
                    end
                end else
`endif
                if (req_valid_i) begin
                    req_d.write = req_write_i;
                    req_d.addr  = req_addr_i;
                    req_d.wdata = req_wdata_i;
                    rdata_d     = '0;
                    last_d      = 1'b1;
                    // A request while running is answered with an error and never
                    // touches the register file.
                    if (halted_i) begin
                        state_d = DM_ACCESS;
                        err_d   = 1'b0;
                    end else begin
                        state_d = DM_RESP;
                        err_d   = 1'b1;
                    end
                end
            end

            DM_ACCESS: begin
                // halted_i is not re-checked: once started, the access completes.
                rdata_d = req_q.write ? '0 : rf_rd_data_i;
                state_d = DM_RESP;
            end

            DM_RESP: begin
                if (rsp_ready_i) begin
                    state_d = DM_IDLE;
                end
            end

`ifdef REGFILE_DUMP_EN
            DM_DUMP: begin
                if (!beat_q) begin
                    // Fetch cycle for the next beat; losing halt turns it into
                    // a terminating error beat served from RESP.
                    if (!halted_i) begin
                        state_d = DM_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                        last_d  = 1'b1;
                    end else begin
                        rdata_d = rf_rd_data_i;
                        last_d  = (idx_q == XWIDTH'(NUM_REGS - 1));
                        beat_d  = 1'b1;
                    end
                end else if (rsp_ready_i) begin
                    beat_d = 1'b0;
                    if (last_q) begin
                        state_d = DM_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = DM_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Ready is masked during reset so every output reads 0 while rst_i is high.
    assign req_ready_o = (state_q == DM_IDLE) && !rst_i;

`ifdef REGFILE_DUMP_EN
    assign rsp_valid_o  = (state_q == DM_RESP) || ((state_q == DM_DUMP) && beat_q);
    assign rf_rd_addr_o = (state_q == DM_DUMP) ? idx_q : req_q.addr;
`else
    assign rsp_valid_o  = (state_q == DM_RESP);
    assign rf_rd_addr_o = req_q.addr;
`endif

    assign rsp_rdata_o  = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o    = rsp_valid_o && err_q;
    assign rsp_last_o   = rsp_valid_o && last_q;

    // Decoded straight from the state register so an asynchronous reset
    // removes a pending write enable immediately.
    assign rf_wr_en_o   = (state_q == DM_ACCESS) && req_q.write;
    assign rf_wr_addr_o = req_q.addr;
    assign rf_wr_data_o = req_q.wdata;

    assign busy_o       = (state_q != DM_IDLE);

endmodule

// File: tb/tb_regfile_debug_master.sv
// tb_regfile_debug_master: directed bench for regfile_debug_master.
// Contains a behavioural 32x32 register file (x0 reads as zero) on the RF port.
// The bulk-dump section is compiled only when REGFILE_DUMP_EN is defined.
module tb_regfile_debug_master;
    import riscv_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              halted = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [XWIDTH-1:0] req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic              dump = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              rsp_last;
    logic [XWIDTH-1:0] rf_rd_addr;
    logic [XLEN-1:0]   rf_rd_data;
    logic [XWIDTH-1:0] rf_wr_addr;
    logic [XLEN-1:0]   rf_wr_data;
    logic              rf_wr_en;
    logic              busy;

    int total = 0;
    int bad   = 0;

    regfile_debug_master dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .halted_i     (halted),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .dump_i       (dump),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_last_o   (rsp_last),
        .rf_rd_addr_o (rf_rd_addr),
        .rf_rd_data_i (rf_rd_data),
        .rf_wr_addr_o (rf_wr_addr),
        .rf_wr_data_o (rf_wr_data),
        .rf_wr_en_o   (rf_wr_en),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Register-file model and write-pulse counter.
    logic [XLEN-1:0] rf_mem [NUM_REGS];
    logic            model_clr = 1'b1;
    int              wr_pulses = 0;

    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= '0;
        end else if (rf_wr_en && rf_wr_addr != '0) begin
            rf_mem[rf_wr_addr] <= rf_wr_data;
        end
        if (rf_wr_en) wr_pulses <= wr_pulses + 1;
    end

    assign rf_rd_data = (rf_rd_addr == '0) ? '0 : rf_mem[rf_rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) at negedges for rsp_valid; an expired bound fails the check.
    task automatic wait_rsp(input string tag);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, rsp_valid}, 32'd1);
    endtask

    // One complete request/response transaction; returns the response fields.
    task automatic do_op(input logic w, input logic [XWIDTH-1:0] a, input logic [XLEN-1:0] d,
                         output logic [XLEN-1:0] rd, output logic er, output logic la);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("op_rsp_valid");
        rd = rsp_rdata;
        er = rsp_err;
        la = rsp_last;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [XLEN-1:0] rd;
    logic            er, la;
    int              pulses_before;

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_wr_en",     {31'd0, rf_wr_en},  32'd0);
        check("rst_rsp_last",  {31'd0, rsp_last},  32'd0);
        rst = 1'b0;
        model_clr = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // ---------------- 1: write x5 with exact timing ----------------
        halted    = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 5'd5;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk);                 // edge N
        @(negedge clk);                 // cycle N+1
        req_valid = 1'b0;
        check("t1_wr_en",      {31'd0, rf_wr_en},  32'd1);
        check("t1_wr_addr",    {27'd0, rf_wr_addr}, 32'd5);
        check("t1_wr_data",    rf_wr_data,         32'hDEADBEEF);
        check("t1_valid_n1",   {31'd0, rsp_valid}, 32'd0);
        check("t1_ready_n1",   {31'd0, req_ready}, 32'd0);
        check("t1_busy",       {31'd0, busy},      32'd1);
        @(negedge clk);                 // cycle N+2
        check("t1_wr_en_off",  {31'd0, rf_wr_en},  32'd0);
        check("t1_valid_n2",   {31'd0, rsp_valid}, 32'd1);
        check("t1_err",        {31'd0, rsp_err},   32'd0);
        check("t1_last",       {31'd0, rsp_last},  32'd1);
        check("t1_rdata",      rsp_rdata,          32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t1_valid_done", {31'd0, rsp_valid}, 32'd0);
        check("t1_ready_done", {31'd0, req_ready}, 32'd1);

        // ---------------- 2: read back x5, x0 write/read ----------------
        do_op(1'b0, 5'd5, 32'd0, rd, er, la);
        check("t2_rd_x5",  rd, 32'hDEADBEEF);
        check("t2_err_x5", {31'd0, er}, 32'd0);
        pulses_before = wr_pulses;
        do_op(1'b1, 5'd0, 32'h1234, rd, er, la);
        check("t2_wr_x0_err",   {31'd0, er}, 32'd0);
        check("t2_wr_x0_pulse", wr_pulses - pulses_before, 32'd1);
        do_op(1'b0, 5'd0, 32'd0, rd, er, la);
        check("t2_rd_x0", rd, 32'd0);

        // ---------------- 3: requests while not halted ----------------
        pulses_before = wr_pulses;
        @(negedge clk);
        halted    = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("t3_valid", {31'd0, rsp_valid}, 32'd1);
        check("t3_err",   {31'd0, rsp_err},   32'd1);
        check("t3_rdata", rsp_rdata,          32'd0);
        check("t3_last",  {31'd0, rsp_last},  32'd1);
        check("t3_ready", {31'd0, req_ready}, 32'd0);
        check("t3_wr_en", {31'd0, rf_wr_en},  32'd0);
        @(negedge clk);
        check("t3_ready_hold", {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t3_ready_back", {31'd0, req_ready}, 32'd1);
        do_op(1'b1, 5'd7, 32'h0000FFFF, rd, er, la);
        check("t3_wr_err",    {31'd0, er}, 32'd1);
        check("t3_no_pulses", wr_pulses - pulses_before, 32'd0);
        halted = 1'b1;
        do_op(1'b0, 5'd7, 32'd0, rd, er, la);
        check("t3_x7_untouched", rd, 32'd0);

        // ---------------- 4: response backpressure ----------------
        do_op(1'b1, 5'd9, 32'hCAFEF00D, rd, er, la);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t4_valid_stall", {31'd0, rsp_valid}, 32'd1);
            check("t4_rdata_stall", rsp_rdata,          32'hCAFEF00D);
            check("t4_ready_stall", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t4_valid_done", {31'd0, rsp_valid}, 32'd0);

        // halted drops during ACCESS: the op still completes cleanly
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        halted    = 1'b0;
        wait_rsp("t4_atomic_valid");
        check("t4_atomic_err",   {31'd0, rsp_err}, 32'd0);
        check("t4_atomic_rdata", rsp_rdata,        32'hCAFEF00D);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        halted    = 1'b1;

        // ---------------- 5: reset during ACCESS of a write ----------------
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 5'd12;
        req_wdata = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("t5_wr_en_before", {31'd0, rf_wr_en}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_wr_en_async", {31'd0, rf_wr_en}, 32'd0);
        check("t5_busy_async",  {31'd0, busy},     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_after", {31'd0, req_ready}, 32'd1);
        do_op(1'b0, 5'd12, 32'd0, rd, er, la);
        check("t5_x12_unwritten", rd, 32'd0);

`ifdef REGFILE_DUMP_EN
        // ---------------- 6: bulk dump ----------------
        for (int i = 1; i < NUM_REGS; i++) begin
            do_op(1'b1, XWIDTH'(i), 32'(i * 4), rd, er, la);
        end
        @(negedge clk);
        dump      = 1'b1;
        req_valid = 1'b1;   // dump has priority; this must be ignored
        req_write = 1'b1;
        req_addr  = 5'd1;
        req_wdata = 32'hBAD0BAD0;
        @(posedge clk);
        @(negedge clk);
        dump      = 1'b0;
        req_valid = 1'b0;
        check("t6_first_gap", {31'd0, rsp_valid}, 32'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            wait_rsp("t6_beat_valid");
            check("t6_rdata", rsp_rdata,          32'(i * 4));
            check("t6_last",  {31'd0, rsp_last},  (i == NUM_REGS - 1) ? 32'd1 : 32'd0);
            check("t6_err",   {31'd0, rsp_err},   32'd0);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        check("t6_idle_after", {31'd0, busy}, 32'd0);

        // dump aborted by halted dropping after beat 9
        @(negedge clk);
        dump = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dump = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_rsp("t6b_beat_valid");
            check("t6b_rdata", rsp_rdata, 32'(i * 4));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        halted = 1'b0;
        wait_rsp("t6b_abort_valid");
        check("t6b_abort_err",   {31'd0, rsp_err},  32'd1);
        check("t6b_abort_last",  {31'd0, rsp_last}, 32'd1);
        check("t6b_abort_rdata", rsp_rdata,         32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t6b_idle", {31'd0, busy}, 32'd0);
        halted = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
